// File: rtl/keypad_pkg.sv
// Shared key-code constants, FSM state type and key-position lookup for the
// 4x4 keypad scanner and emulator.
package keypad_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] row;  // one-hot row
    logic [3:0] col;  // one-hot column
  } key_pos_t;

  function automatic key_pos_t key_pos(input logic [3:0] code);
    key_pos_t   p;
    logic [1:0] r;
    logic [1:0] c;
    r = 2'd0;
    c = 2'd0;
    case (code)
      KEY_1: begin r = 2'd0; c = 2'd0; end
      KEY_2: begin r = 2'd0; c = 2'd1; end
      KEY_3: begin r = 2'd0; c = 2'd2; end
      KEY_A: begin r = 2'd0; c = 2'd3; end
      KEY_4: begin r = 2'd1; c = 2'd0; end
      KEY_5: begin r = 2'd1; c = 2'd1; end
      KEY_6: begin r = 2'd1; c = 2'd2; end
      KEY_B: begin r = 2'd1; c = 2'd3; end
      KEY_7: begin r = 2'd2; c = 2'd0; end
      KEY_8: begin r = 2'd2; c = 2'd1; end
      KEY_9: begin r = 2'd2; c = 2'd2; end
      KEY_C: begin r = 2'd2; c = 2'd3; end
      KEY_F: begin r = 2'd3; c = 2'd0; end
      KEY_0: begin r = 2'd3; c = 2'd1; end
      KEY_E: begin r = 2'd3; c = 2'd2; end
      KEY_D: begin r = 2'd3; c = 2'd3; end
      default: begin r = 2'd0; c = 2'd0; end
    endcase
    p.row = 4'b0001 << r;
    p.col = 4'b0001 << c;
    return p;
  endfunction

endpackage

// File: rtl/keypad_bounce_gen.sv
// Contact-bounce generator: on start, jumps to the target level, toggles
// TOGGLES times every PERIOD cycles, then settles at the target level.
module keypad_bounce_gen #(
  parameter int TOGGLES = 6,
  parameter int PERIOD  = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic level,
  output logic contact
);

  localparam int PW = $clog2(PERIOD) + 1;
  localparam int TW = $clog2(TOGGLES + 1) + 1;

  logic [PW-1:0] tcnt;
  logic [TW-1:0] remain;
  logic          target;

  always_ff @(posedge clk) begin
    if (rst) begin
      contact <= 1'b0;
      target  <= 1'b0;
      remain  <= '0;
      tcnt    <= '0;
    end else if (start) begin
      contact <= level;
      target  <= level;
      remain  <= TW'(TOGGLES);
      tcnt    <= '0;
    end else if (remain != '0) begin
      if (tcnt == PW'(PERIOD - 1)) begin
        contact <= ~contact;
        remain  <= remain - TW'(1);
        tcnt    <= '0;
      end else begin
        tcnt <= tcnt + PW'(1);
      end
    end else begin
      contact <= target;
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad emulator: presses a handshaken key for HOLD_CYCLES, then
// forces release for RELEASE_CYCLES. Optional bounce: KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES    = 4000000,
  parameter int RELEASE_CYCLES = 2000000,
  parameter int BOUNCE_TOGGLES = 6,
  parameter int BOUNCE_PERIOD  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] rowN_in,
  output logic [3:0] columnN_out,
  output logic       pressed,
  output logic       busy,
  output logic       key_done
);

  localparam int MAX_HR = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int MAX_C  = (MAX_HR > BOUNCE_PERIOD) ? MAX_HR : BOUNCE_PERIOD;
  localparam int CW     = $clog2(MAX_C) + 1;

  if (HOLD_CYCLES < 1 || RELEASE_CYCLES < 1 || BOUNCE_TOGGLES < 0 || BOUNCE_PERIOD < 1)
  begin : g_param_err
    $error("keypad_emulator: illegal parameter value");
  end

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    key_q;
  logic [3:0]    col_nxt;
  logic          accept;
  logic          contact;
  logic          row_low;
  key_pos_t      pos;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      key_q       <= '0;
      columnN_out <= 4'b1111;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      columnN_out <= col_nxt;
      if (accept) key_q <= key_in;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    key_ready = 1'b0;
    busy      = 1'b1;
    key_done  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        busy      = 1'b0;
        cnt_nxt   = '0;
        if (key_valid) begin
          accept    = 1'b1;
          state_nxt = PRESS;
        end
      end
      PRESS: begin
        if (cnt == CW'(HOLD_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = RELEASE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RELEASE: begin
        if (cnt == CW'(RELEASE_CYCLES - 1)) begin
          key_done  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        busy      = 1'b0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic bounce_start;
  // Bounce restarts on both edges of the logical press; target is the new level.
  assign bounce_start = accept || (state == PRESS && state_nxt == RELEASE);

  keypad_bounce_gen #(
    .TOGGLES (BOUNCE_TOGGLES),
    .PERIOD  (BOUNCE_PERIOD)
  ) u_bounce (
    .clk     (clk),
    .rst     (rst),
    .start   (bounce_start),
    .level   (accept),
    .contact (contact)
  );
`else
  assign contact = (state == PRESS);
`endif

  assign pressed = contact;
  assign pos     = key_pos(key_q);
  // Other rows being low at the same time does not mask the target row.
  assign row_low = ((rowN_in & pos.row) == 4'b0000);
  assign col_nxt = ~(pos.col & {4{contact && row_low}});

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
Synthesizable model of a 4x4 matrix keypad; the responding end of the row-scan/column-sense interface driven by the keypad scanner.
- Accepts a 4-bit key code via valid/ready handshake.
- Holds the matching switch closed for a programmable time, then releases it.
- Drives active-low column lines whenever the scanner drives the key's row low.
- Used for on-board self-test of the scanner/ALU input path and as a bench stimulus model.

Parameters:
HOLD_CYCLES, 4000000, cycles the key stays pressed; must cover at least 4 scan slots plus debounce; minimum 1
RELEASE_CYCLES, 2000000, cycles of forced release after a press before the next key is accepted; minimum 1
BOUNCE_TOGGLES, 6, contact toggles at each press/release edge (BOUNCE_EN only)
BOUNCE_PERIOD, 1000, cycles between bounce toggles (BOUNCE_EN only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
key_in  in  4  key code to press
key_valid  in  1  key_in is valid
key_ready  out  1  emulator idle, will accept key_in
rowN_in  in  4  active-low row drive from scanner; bit i = row i
columnN_out  out  4  active-low column sense to scanner; bit j = column j
pressed  out  1  contact currently closed (logical, pre-row gating)
busy  out  1  press or release in progress
key_done  out  1  one-cycle pulse at end of release

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: columnN_out=4'b1111, key_ready=1, pressed=0, busy=0, key_done=0, state IDLE, counters 0. Reset mid-operation aborts the press. Columns release on the next edge and key_done does not pulse.
- Key map, code -> (row, column):
  - row0: 1->c0, 2->c1, 3->c2, A->c3
  - row1: 4->c0, 5->c1, 6->c2, B->c3
  - row2: 7->c0, 8->c1, 9->c2, C->c3
  - row3: F->c0, 0->c1, E->c2, D->c3
  - All 16 codes are legal.
- FSM IDLE -> PRESS -> RELEASE -> IDLE.
  - IDLE: key_ready=1, busy=0. A transfer occurs when key_valid&&key_ready at a rising edge. key_in is latched at that edge and the state goes to PRESS.
  - PRESS: pressed=1 for exactly HOLD_CYCLES cycles, then RELEASE.
  - RELEASE: pressed=0 for exactly RELEASE_CYCLES cycles. key_done=1 during the final RELEASE cycle, then IDLE.
  - key_ready=0 and busy=1 throughout PRESS and RELEASE. key_valid there is ignored and no code is latched.
- Column drive is registered, one-cycle latency:
  - columnN_out[c] <= ~(pressed_contact && ~rowN_in[r]), where (r,c) is the latched key position.
  - All other column bits are 1.
  - Multiple rows low at once is tolerated: the target column is asserted if the target row bit is low.
- Counter width: $clog2 of the largest of HOLD_CYCLES, RELEASE_CYCLES, BOUNCE_PERIOD, plus 1. The counter never wraps; the terminal count is compared exactly.

Optional Feature:
KEYPAD_EMU_BOUNCE_EN
- Defined:
  - At PRESS entry and RELEASE entry, the contact toggles BOUNCE_TOGGLES times, one toggle every BOUNCE_PERIOD cycles, before settling.
  - Bounce time is counted inside HOLD_CYCLES / RELEASE_CYCLES. Require HOLD_CYCLES and RELEASE_CYCLES > BOUNCE_TOGGLES*BOUNCE_PERIOD.
  - pressed reflects the bouncing contact.
- Undefined: clean contact; bounce parameters are unused and no bounce logic is elaborated.

Decomposition:
- Shared package keypad_pkg:
  - KEY_0..KEY_F code constants.
  - State enum (IDLE, PRESS, RELEASE).
  - Function key_pos(code) returning one-hot row and one-hot column. The scanner and emulator share this package.
- Sub-module keypad_bounce_gen, instantiated only under KEYPAD_EMU_BOUNCE_EN:
  - Input: a start pulse and target level.
  - Output: bouncing contact level.

Test Plan (HOLD_CYCLES=20, RELEASE_CYCLES=10 unless noted):
1. rst=1 for 2 cycles with key_valid=1 -> columnN_out=4'b1111, key_ready=1, busy=0, key_done=0; no key latched.
2. key_in=4'h5 accepted; rowN_in=4'b1101 -> next cycle columnN_out=4'b1101; rowN_in=4'b1110 -> 4'b1111.
3. key_in=4'h0, rowN_in=4'b0111 -> 4'b1101. key_in=4'hD -> 4'b0111. key_in=4'h1 with rowN_in=4'b1110 -> 4'b1110.
4. Accept at edge E0 -> pressed=1 for 20 cycles, then 0 for 10 cycles; key_done high only in cycle 30 after E0; key_ready=1 at cycle 31. A second key_valid with key_in=4'h9 at cycle 5 is not accepted.
5. rst asserted at cycle 10 of PRESS -> next edge columnN_out=4'b1111, IDLE, no key_done pulse.
6. KEYPAD_EMU_BOUNCE_EN with BOUNCE_TOGGLES=4, BOUNCE_PERIOD=3, key_in=4'h2, row0 driven -> column1 shows 4 transitions spaced 3 cycles, then holds low; mirror behaviour at release.
